// File: rtl/dmem_responder.sv
// Fixed-latency word-organised data memory answering CPU data-port reads/writes
// with a one-cycle mem_resp pulse; storage, state and read data clear on reset.
module dmem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_resp
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_wr_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [1:0]             be_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [DATA_W-1:0]      mem_q [DEPTH];

  logic                   accept_c;
  logic                   load_rd_c;
  logic                   commit_c;
  logic [ADDR_BITS-1:0]   rd_idx_c;
  logic                   unused_addr_bits;

  // Address bit 0 and bits above the word index alias onto the same storage
  assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath control; with LATENCY=1 the read index comes straight from the port
  always_comb begin
    accept_c  = 1'b0;
    load_rd_c = 1'b0;
    commit_c  = 1'b0;
    rd_idx_c  = idx_q;
    if (state_q == IDLE) begin
      accept_c = mem_read || mem_write;
      rd_idx_c = mem_address[ADDR_BITS:1];
      if (state_d == RESP) load_rd_c = !mem_write;
    end else if (state_q == BUSY) begin
      if (state_d == RESP) load_rd_c = !is_wr_q;
    end else if (state_q == RESP) begin
      commit_c = is_wr_q;
    end
  end

  // Request capture, read data and storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (accept_c) begin
        is_wr_q <= mem_write;
        idx_q   <= mem_address[ADDR_BITS:1];
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
      end
      if (load_rd_c) rdata_q <= mem_q[rd_idx_c];
      if (commit_c) begin
        if (be_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
        if (be_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = (state_q == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=3 instance and a LATENCY=1 instance
// share clock and reset; expected responses are queued at drive time and popped on mem_resp.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd0, wr0, rd1, wr1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic [1:0]  be0, be1;
  logic [15:0] rdata0, rdata1;
  logic        resp0, resp1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [15:0] model [2][256];
  logic [15:0] last_rd [2];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_BITS(8), .LATENCY(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0),
    .mem_address(addr0), .mem_wdata(wdata0), .mem_byte_enable(be0),
    .mem_rdata(rdata0), .mem_resp(resp0)
  );

  dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
    .mem_address(addr1), .mem_wdata(wdata1), .mem_byte_enable(be1),
    .mem_rdata(rdata1), .mem_resp(resp1)
  );

  function automatic logic get_resp(input int d);
    return (d == 1) ? resp1 : resp0;
  endfunction

  function automatic logic [15:0] get_rdata(input int d);
    return (d == 1) ? rdata1 : rdata0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      model[0][i] = 16'h0000;
      model[1][i] = 16'h0000;
    end
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
  endtask

  task automatic drive(input int d, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic [1:0] be);
    if (d == 1) begin
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = wd; be1 = be;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = a; wdata0 = wd; be0 = be;
    end
  endtask

  // Queue the expected outcome of one access, as seen by an independent memory model
  task automatic push_expect(input int d, input logic wr, input logic [15:0] a,
                             input logic [15:0] wd, input logic [1:0] be, input int lat);
    exp_t e;
    logic [7:0] idx;
    idx = a[8:1];
    if (wr) begin
      if (be[0]) model[d][idx][7:0]  = wd[7:0];
      if (be[1]) model[d][idx][15:8] = wd[15:8];
    end else begin
      last_rd[d] = model[d][idx];
    end
    e.data = last_rd[d];
    e.lat  = lat;
    sb.push_back(e);
  endtask

  // One complete access; drop_at>0 releases the request at that many cycles after acceptance
  task automatic access(input int d, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be, input int drop_at,
                        input string name);
    int   k;
    logic got;
    exp_t e;
    @(negedge clk);
    drive(d, rd, wr, a, wd, be);
    push_expect(d, wr, a, wd, be, (d == 1) ? 1 : 3);
    k = 0;
    got = 1'b0;
    while (k < 20 && !got) begin
      @(negedge clk);
      k++;
      if (get_resp(d)) got = 1'b1;
      else if (k == drop_at) drive(d, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    end
    drive(d, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    e = sb.pop_front();
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_resp_timeout: no mem_resp within %0d cycles", name, k);
    end else if (k != e.lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles want %0d", name, k, e.lat);
    end
    vectors++;
    if (get_rdata(d) !== e.data) begin
      miscompares++;
      $display("FAIL %s_rdata: got %h want %h", name, get_rdata(d), e.data);
    end
    @(negedge clk);
    vectors++;
    if (get_resp(d) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_resp_width: mem_resp got %b want 0 after one cycle", name, get_resp(d));
    end
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (resp0 !== 1'b0 || resp1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_resp: got %b/%b want 0/0", resp0, resp1);
    end
    vectors++;
    if (rdata0 !== 16'h0000 || rdata1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h/%h want 0000/0000", rdata0, rdata1);
    end
    access(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 0, "reset_read");
  endtask

  task automatic test_write_read();
    access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 0, "wr_beef");
    vectors++;
    if (rdata0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL wr_keeps_rdata: got %h want 0000", rdata0);
    end
    access(0, 1'b1, 1'b0, 16'h0011, 16'h0000, 2'b00, 0, "rd_odd_addr");
    vectors++;
    if (rdata0 !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL rd_odd_addr_const: got %h want BEEF", rdata0);
    end
  endtask

  task automatic test_byte_enables();
    access(0, 1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01, 0, "wr_be01");
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 0, "rd_be01");
    vectors++;
    if (rdata0 !== 16'hBE34) begin
      miscompares++;
      $display("FAIL rd_be01_const: got %h want BE34", rdata0);
    end
    access(0, 1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, 0, "wr_be00");
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 0, "rd_be00");
    access(0, 1'b0, 1'b1, 16'h0210, 16'hAB00, 2'b10, 0, "wr_alias_hi");
    access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 0, "rd_alias_hi");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    access(0, 1'b0, 1'b1, 16'h0004, 16'h0020, 2'b11, 0, "ldi_ptr");
    access(0, 1'b0, 1'b1, 16'h0020, 16'h5A5A, 2'b11, 0, "ldi_data");
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0004, 16'h0000, 2'b00);
    push_expect(0, 1'b0, 16'h0004, 16'h0000, 2'b00, 3);
    push_expect(0, 1'b0, 16'h0020, 16'h0000, 2'b00, 7);
    n = 0;
    for (int k = 1; k <= 20 && n < 2; k++) begin
      @(negedge clk);
      if (resp0) begin
        e = sb.pop_front();
        n++;
        vectors++;
        if (k != e.lat) begin
          miscompares++;
          $display("FAIL b2b_latency_%0d: got cycle %0d want %0d", n, k, e.lat);
        end
        vectors++;
        if (rdata0 !== e.data) begin
          miscompares++;
          $display("FAIL b2b_rdata_%0d: got %h want %h", n, rdata0, e.data);
        end
        if (n == 1) addr0 = 16'h0020;
      end
    end
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d responses want 2", n);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_mid_drop();
    access(0, 1'b0, 1'b1, 16'h0030, 16'h7777, 2'b11, 1, "wr_drop");
    access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 0, "rd_after_drop");
    vectors++;
    if (rdata0 !== 16'h7777) begin
      miscompares++;
      $display("FAIL rd_after_drop_const: got %h want 7777", rdata0);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0032, 16'hC0DE, 2'b11);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp0) n++;
    end
    vectors++;
    if (n != 0) begin
      miscompares++;
      $display("FAIL reset_abort_resp: got %0d responses want 0", n);
    end
    access(0, 1'b1, 1'b0, 16'h0032, 16'h0000, 2'b00, 0, "rd_after_abort");
    vectors++;
    if (rdata0 !== 16'h0000) begin
      miscompares++;
      $display("FAIL rd_after_abort_const: got %h want 0000", rdata0);
    end
  endtask

  task automatic test_lat1();
    access(1, 1'b0, 1'b1, 16'h0004, 16'h1111, 2'b11, 0, "l1_wr");
    access(1, 1'b1, 1'b0, 16'h0004, 16'h0000, 2'b00, 0, "l1_rd");
    access(1, 1'b1, 1'b1, 16'h0008, 16'h00FF, 2'b11, 0, "l1_both");
    vectors++;
    if (rdata1 !== 16'h1111) begin
      miscompares++;
      $display("FAIL l1_both_rdata_kept: got %h want 1111", rdata1);
    end
    access(1, 1'b1, 1'b0, 16'h0008, 16'h0000, 2'b00, 0, "l1_rd_both");
    vectors++;
    if (rdata1 !== 16'h00FF) begin
      miscompares++;
      $display("FAIL l1_rd_both_const: got %h want 00FF", rdata1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_back_to_back();
    test_mid_drop();
    test_reset_mid();
    test_lat1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
